div_unit: RTL and testbench

// - Multi-cycle 32-bit signed/unsigned divider for DIV/DIVU, driven by EX; EX holds stallreq high until ready_o.
// - Radix-2 restoring divide, one quotient bit per cycle; result {remainder, quotient} is written to HI/LO.
// - Sits beside EX inside the core; EX drives start/operands; control stalls upstream stages meanwhile.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit.sv | 174 +++++++++++++++++
 tb/tb_div_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the multi-cycle DIV/DIVU unit: the divider state
// encoding and the ready/start handshake levels used by EX and the divider.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  // Divider control states. The encodings match the legacy core defines.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Width of the {remainder, quotient} bus written to HI/LO
  localparam int DOUBLE_REG_W = 64;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU (unsigned).
// One quotient bit is produced per clock. Operands are reduced to magnitudes
// at start; signs are re-applied to quotient and remainder in the final cycle.
// EX keeps start_i high (and stalls upstream) until it has consumed ready_o.
//
// Ports
//   clk           core clock
//   rst           synchronous active-high reset, allowed mid-divide
//   signed_div_i  1 = DIV, 0 = DIVU; latched with start
//   opdata1_i     dividend; latched when a start is accepted
//   opdata2_i     divisor;  latched when a start is accepted
//   start_i       request, held by EX until result consumed
//   annul_i       flush; kills an in-flight divide (ignored once done)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  // Two's-complement negate, modulo 2^DATA_W
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] sv;
    sv = $signed(v);
    return $unsigned(-sv);
  endfunction

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // work[2W:W] is the partial remainder window, work[W-1:0] collects quotient
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg1_q, neg1_d;     // signed op and dividend negative
  logic                  neg2_q, neg2_d;     // signed op and divisor negative
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quot_raw, rem_raw;
  logic [DATA_W-1:0]     quot_fix, rem_fix;
  logic                  cnt_done;

  // Operand magnitudes computed from the live inputs; only used on the
  // accepting edge, after which the latched copies are authoritative.
  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? negate(opdata1_i) : opdata1_i;
  assign op2_abs = op2_neg ? negate(opdata2_i) : opdata2_i;

  // 33-bit trial subtract; diff[DATA_W] set means the divisor did not fit
  assign diff = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

  assign cnt_done = (cnt_q == CNT_W'(DATA_W));

  // Sign fixup: remainder follows the dividend, quotient follows sign XOR.
  // 0x80000000 / -1 wraps back to 0x80000000 with no trap.
  assign quot_raw = work_q[DATA_W-1:0];
  assign rem_raw  = work_q[2*DATA_W:DATA_W+1];
  assign quot_fix = (neg1_q ^ neg2_q) ? negate(quot_raw) : quot_raw;
  assign rem_fix  = neg1_q ? negate(rem_raw) : rem_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i == DIV_START && !annul_i) begin
          neg1_d = op1_neg;
          neg2_d = op2_neg;
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            divisor_d = op2_abs;
            work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          end
        end
      end

      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          // Divide-by-zero is architecturally unpredictable; report 0/0
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
          ready_d = DIV_RESULT_NOT_READY;
        end else if (!cnt_done) begin
          if (diff[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
          cnt_d    = '0;
        end
      end

      DIV_END: begin
        // Hold until EX drops start; annul is ignored once the result exists
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit. Inputs change on the falling edge or just after
// a rising edge; outputs are sampled 1 ns after the rising edge.
// Edge counts include the edge that samples start_i.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // Raise start with the given operands and count edges until ready_o.
  // After the sampling edge the inputs are scrambled so that a design which
  // fails to latch operands or the signed flag produces a wrong result.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int edges);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    edges        = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom | 32'h1;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic end_div();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o);
    end
    n_checks++;
    if (result_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", result_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int e;
    do_div(1'b0, 32'd100, 32'd7, e);
    n_checks++;
    if (e !== 34) begin
      n_fail++; $display("FAIL udiv_latency: got %0d edges want 34", e);
    end
    n_checks++;
    if (result_o !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL udiv_100_7: got %h want %h", result_o, {32'd2, 32'd14});
    end
    end_div();
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL udiv_release: got ready=%b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int e;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, e);
    n_checks++;
    if (e !== 34 || result_o !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL sdiv_m7_2: got %h edges=%0d want FFFFFFFFFFFFFFFD edges=34", result_o, e);
    end
    end_div();
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, e);
    n_checks++;
    if (result_o !== 64'h0000_0001_FFFF_FFFD) begin
      n_fail++; $display("FAIL sdiv_7_m2: got %h want 00000001FFFFFFFD", result_o);
    end
    end_div();
    do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, e);
    n_checks++;
    if (result_o !== 64'hFFFF_FFFF_0000_0003) begin
      n_fail++; $display("FAIL sdiv_m7_m2: got %h want FFFFFFFF00000003", result_o);
    end
    end_div();
  endtask

  task automatic test_byzero();
    int e;
    do_div(1'b0, 32'd5, 32'd0, e);
    n_checks++;
    if (e !== 2) begin
      n_fail++; $display("FAIL byzero_latency: got %0d edges want 2", e);
    end
    n_checks++;
    if (result_o !== 64'h0) begin
      n_fail++; $display("FAIL byzero_result: got %h want 0", result_o);
    end
    end_div();
  endtask

  task automatic test_boundaries();
    int e;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e);
    n_checks++;
    if (result_o !== 64'h0000_0000_8000_0000) begin
      n_fail++; $display("FAIL bnd_minint_m1: got %h want 0000000080000000", result_o);
    end
    end_div();
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, e);
    n_checks++;
    if (result_o !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++; $display("FAIL bnd_umax_1: got %h want 00000000FFFFFFFF", result_o);
    end
    end_div();
    do_div(1'b0, 32'd3, 32'hFFFF_FFFF, e);
    n_checks++;
    if (result_o !== 64'h0000_0003_0000_0000) begin
      n_fail++; $display("FAIL bnd_3_umax: got %h want 0000000300000000", result_o);
    end
    end_div();
  endtask

  task automatic test_annul();
    int e;
    // annul together with start in FREE must not launch a divide
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd0;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL annul_free: got ready=%b want 0", ready_o);
    end
    // start 1000/7, annul once cnt has reached 10
    @(negedge clk);
    annul_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL annul_on: got ready=%b result=%h want 0/0", ready_o, result_o);
    end
    // immediate new start 9/3 with start still held
    @(negedge clk);
    annul_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    e = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        e = i;
        break;
      end
    end
    n_checks++;
    if (e !== 34) begin
      n_fail++; $display("FAIL annul_restart_latency: got %0d edges want 34", e);
    end
    n_checks++;
    if (result_o !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL annul_restart_9_3: got %h want 0000000000000003", result_o);
    end
    // annul in END is ignored
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b1 || result_o !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL annul_end: got ready=%b result=%h want 1/0000000000000003", ready_o, result_o);
    end
    @(negedge clk);
    annul_i = 1'b0;
    end_div();
  endtask

  task automatic test_handshake();
    int e;
    do_div(1'b0, 32'd47, 32'd5, e);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd9}) begin
        n_fail++; $display("FAIL hold_end[%0d]: got ready=%b result=%h want 1/0000000200000009", k, ready_o, result_o);
      end
    end
    end_div();
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL release_ready: got %b want 0", ready_o);
    end
    n_checks++;
    if (result_o !== 64'h0) begin
      n_fail++; $display("FAIL release_result: got %h want 0", result_o);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid: got ready=%b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle: got ready=%b want 0", ready_o);
    end
    // unit must be back in FREE with full latency
    do_div(1'b0, 32'd100, 32'd7, e);
    n_checks++;
    if (e !== 34 || result_o !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL rst_mid_after: got %h edges=%0d want 000000020000000E edges=34", result_o, e);
    end
    end_div();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_boundaries();
    test_annul();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_unit
